reorder_buffer: RTL and testbench
=================================

# reorder_buffer

64-entry reorder buffer for the out-of-order core, closing the loop between the forwarding buses and the architectural register file. It allocates up to four instructions per cycle in program order from decode and captures results from forward buses A–D. It retires up to two completed instructions per cycle, in order, onto the two write ports of `regs`.

## Interface
- `DEPTH`, 64: number of entries; must be a power of two.
- `IDXW`, 6: entry index width, log2(`DEPTH`).
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `flush` input 1: synchronous; discards every entry.
- `alloc_valid` input 4: lane mask for lanes A–D, bit 0 = A. Legal values are 0000, 0001, 0011, 0111 and 1111 only.
- `alloc_wr` input 4: per lane, the instruction writes a register.
- `alloc_dest` input 12: per lane destination register, 3 bits each, lane A at [2:0].
- `alloc_pc` input 64: per lane PC, 16 bits each, lane A at [15:0].
- `alloc_ready` output 1: high when the buffer can accept a full group of 4.
- `alloc_idx` output 24: entry index for each lane, 6 bits each, lane A at [5:0].
- `forwardA`..`forwardD` input 23 each: bit [22] valid, [21:16] entry index, [15:0] value.
- `wen0`, `wen1` output 1: register write enables.
- `waddr0`, `waddr1` output 3: register write addresses.
- `wdata0`, `wdata1` output 16: register write data.
- `commit_pc0`, `commit_pc1` output 16: PC of each retired instruction.
- `commit_valid` output 2: bit n is high when retire slot n retired an entry this cycle.
- `rob_count` output 7: number of occupied entries.
- `rob_empty` output 1: high when `rob_count` is 0.

## Operation
- Entry fields: `busy`, `done`, `wr`, `dest[2:0]`, `value[15:0]`, `pc[15:0]`.
- Pointers: `head` and `tail` are IDXW bits wide and wrap modulo `DEPTH`. The `count` register is 7 bits.
- `alloc_idx` lane k = (`tail` + k) mod 64. This output is combinational from `tail` and valid even while `alloc_valid` is 0.
- `alloc_ready` = (`count` <= 60). It uses the registered `count` only; same-cycle retires are not credited.
- Allocation fires when `alloc_ready` is high and `alloc_valid` is nonzero. Each lane in the mask writes its entry with `busy=1`, `done=0` and its `wr`, `dest` and `pc`. `tail` advances by popcount(`alloc_valid`).
- Allocation with `alloc_ready` low is ignored: no state change.
- Forward capture: for each bus with valid set whose target entry is `busy`, write `value` and set `done=1`.
  - A forward to a non-busy entry is dropped.
  - When several buses target the same index, the highest-lettered bus wins (D over C over B over A).
- Retire slot 0 fires when entry `head` is `busy` and `done`. Slot 1 fires when slot 0 fires and entry `head`+1 is `busy` and `done`. Retirement is strictly in order.
- A retired entry clears `busy`. `head` advances by the number retired.
- Slot n register outputs: `wen`n = retired & `wr`; `waddr`n = `dest`; `wdata`n = `value`. `commit_pc`n = `pc`.
- Simultaneous allocate and retire: `count` <= `count` + allocated − retired.
- Same-index write conflicts:
  - A forward and an allocation to the same index cannot occur legally, because a non-busy index is not a forward target.
  - If it does occur, allocation wins.
- `flush`: all `busy` cleared; `head`, `tail` and `count` set to 0. `flush` overrides same-cycle allocation, forward capture and retirement. All `wen` and `commit_valid` outputs are low on the following cycle.
- Reset: same effect as `flush`, but asynchronous. All outputs go to 0 except `alloc_ready`=1 and `rob_empty`=1; `alloc_idx` then shows 0,1,2,3.

## Timing
- Retire selection is combinational on registered `done` and `busy`. Commit outputs are registered.
- A forward on edge k produces its register write visible after edge k+1: one cycle of forward-to-writeback latency.
- There is no same-cycle bypass from a forward bus into retirement.
- At most 2 retires per cycle. A third completed entry waits one more cycle.
- `rob_count`, `rob_empty` and `alloc_ready` reflect state after the most recent edge.
- Wrap-around: an allocation group of 4 at `tail`=62 occupies indices 62, 63, 0, 1. Retirement across 63→0 is seamless.
- The buffer is full at 64 entries. `alloc_ready` drops once `count` reaches 61, so some capacity is intentionally unused at the allocation granularity.

## Structure
- Shared package `ooo_pkg`:
  - `ROB_IDXW`=6 and `ROB_DEPTH`=64.
  - Forward bus field positions (`FWD_VALID`=22, index [21:16], value [15:0]).
  - Entry struct typedef.
- One natural sub-module: `rob_forward_capture`. It decodes the four buses per entry with the D-priority rule and outputs a per-entry write-enable and value.
- Everything else (pointers, allocation, retire select) stays in `reorder_buffer`.

## Test plan
- Reset, then allocate 4 entries (pc 0, 2, 4, 6; dest r1–r4; all `wr`=1) → `alloc_idx`=0,1,2,3; `rob_count`=4; no `wen` asserted.
- ForwardB hits entry 1 (value 0x0055), then forwardA hits entry 0 (value 0x00AA) one cycle later → retirement waits for entry 0. On the cycle after entry 0 completes, both slots retire: `wen0`/`waddr0`=1/`wdata0`=0x00AA and `wen1`/`waddr1`=2/`wdata1`=0x0055.
- ForwardA and forwardD target entry 3 in the same cycle with values 0x1111 and 0x2222 → entry 3 retires with `wdata` 0x2222.
- Fill to 60 entries, allocate 4 more → `alloc_ready` goes low at count 64. A further allocation attempt leaves `tail` unchanged. Two retires bring `count` to 62, and `alloc_ready` stays low.
- Start at `tail`=62 and allocate 4 → indices 62, 63, 0, 1. Complete all four and retire in two cycles in PC order; `head` ends at 2.
- Assert `flush` with 10 busy entries and a concurrent allocation plus forward → next cycle `rob_count`=0, `rob_empty`=1, `wen0`=`wen1`=0. Then assert `reset` asynchronously mid-cycle → outputs clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ooo_pkg.sv
// Shared types and constants for the out-of-order core.
// Reorder buffer geometry, forward bus layout and entry record.
package ooo_pkg;

  localparam int ROB_IDXW  = 6;
  localparam int ROB_DEPTH = 64;
  localparam int ROB_LANES = 4;
  localparam int NUM_FWD   = 4;

  localparam int FWD_W      = 23;
  localparam int FWD_VALID  = 22;
  localparam int FWD_IDX_HI = 21;
  localparam int FWD_IDX_LO = 16;
  localparam int FWD_VAL_HI = 15;
  localparam int FWD_VAL_LO = 0;

  typedef logic [FWD_W-1:0] fwd_bus_t;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        wr;
    logic [2:0]  dest;
    logic [15:0] value;
    logic [15:0] pc;
  } rob_entry_t;

  function automatic logic [2:0] lane_count(input logic [3:0] m);
    return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Decode/forward/regfile bundle of the reorder buffer.
// master drives allocation and forwards, slave is the buffer.
interface reorder_buffer_if;
  import ooo_pkg::*;

  logic                        flush;
  logic [ROB_LANES-1:0]        alloc_valid;
  logic [ROB_LANES-1:0]        alloc_wr;
  logic [3*ROB_LANES-1:0]      alloc_dest;
  logic [16*ROB_LANES-1:0]     alloc_pc;
  logic                        alloc_ready;
  logic [ROB_IDXW*ROB_LANES-1:0] alloc_idx;
  fwd_bus_t                    forwardA;
  fwd_bus_t                    forwardB;
  fwd_bus_t                    forwardC;
  fwd_bus_t                    forwardD;
  logic                        wen0;
  logic                        wen1;
  logic [2:0]                  waddr0;
  logic [2:0]                  waddr1;
  logic [15:0]                 wdata0;
  logic [15:0]                 wdata1;
  logic [15:0]                 commit_pc0;
  logic [15:0]                 commit_pc1;
  logic [1:0]                  commit_valid;
  logic [ROB_IDXW:0]           rob_count;
  logic                        rob_empty;

  modport master (
    output flush, alloc_valid, alloc_wr,
    output alloc_dest, alloc_pc,
    output forwardA, forwardB,
    output forwardC, forwardD,
    input  alloc_ready, alloc_idx,
    input  wen0, wen1, waddr0, waddr1,
    input  wdata0, wdata1,
    input  commit_pc0, commit_pc1,
    input  commit_valid,
    input  rob_count, rob_empty
  );

  modport slave (
    input  flush, alloc_valid, alloc_wr,
    input  alloc_dest, alloc_pc,
    input  forwardA, forwardB,
    input  forwardC, forwardD,
    output alloc_ready, alloc_idx,
    output wen0, wen1, waddr0, waddr1,
    output wdata0, wdata1,
    output commit_pc0, commit_pc1,
    output commit_valid,
    output rob_count, rob_empty
  );

endinterface

// File: rtl/rob_forward_capture.sv
// Per-entry decode of the four forward buses.
// Only busy entries capture; bus D beats C beats B beats A.
module rob_forward_capture import ooo_pkg::*; #(
  parameter int DEPTH = ROB_DEPTH,
  parameter int IDXW  = ROB_IDXW
) (
  input  fwd_bus_t [NUM_FWD-1:0]   fwd_i,
  input  logic [DEPTH-1:0]         busy_i,
  output logic [DEPTH-1:0]         we_o,
  output logic [DEPTH-1:0][15:0]   val_o
);

  // scan A..D in order so a later-lettered hit overwrites
  always_comb begin
    we_o  = '0;
    val_o = '0;
    for (int e = 0; e < DEPTH; e++) begin
      for (int b = 0; b < NUM_FWD; b++) begin
        if (fwd_i[b][FWD_VALID] && busy_i[e] &&
            (fwd_i[b][FWD_IDX_HI:FWD_IDX_LO] == IDXW'(e))) begin
          we_o[e]  = 1'b1;
          val_o[e] = fwd_i[b][FWD_VAL_HI:FWD_VAL_LO];
        end
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// 64-entry reorder buffer: 4-wide in-order allocate,
// forward-bus completion, 2-wide in-order retire.
module reorder_buffer import ooo_pkg::*; #(
  parameter int DEPTH = ROB_DEPTH,
  parameter int IDXW  = ROB_IDXW
) (
  input logic            clk,
  input logic            reset,
  reorder_buffer_if.slave bus
);

  typedef logic [IDXW-1:0] idx_t;
  typedef logic [IDXW:0]   cnt_t;

  rob_entry_t [DEPTH-1:0] ent_q, ent_d;
  idx_t head_q, head_d;
  idx_t tail_q, tail_d;
  idx_t head1;
  cnt_t count_q, count_d;
  idx_t lane_idx [ROB_LANES];

  logic [DEPTH-1:0]        busy_vec;
  logic [DEPTH-1:0]        fwd_we;
  logic [DEPTH-1:0][15:0]  fwd_val;
  fwd_bus_t [NUM_FWD-1:0]  fwd_arr;

  logic       ready, do_alloc;
  logic       ret0, ret1;
  logic [2:0] n_alloc;
  logic [1:0] n_ret;

  logic [1:0]        wen_q, wen_d;
  logic [1:0]        cv_q, cv_d;
  logic [1:0][2:0]   waddr_q, waddr_d;
  logic [1:0][15:0]  wdata_q, wdata_d;
  logic [1:0][15:0]  cpc_q, cpc_d;

  // entry index offered to each allocation lane
  always_comb begin
    for (int k = 0; k < ROB_LANES; k++)
      lane_idx[k] = tail_q + idx_t'(k);
  end

  // gather busy bits and forward buses for capture
  always_comb begin
    for (int e = 0; e < DEPTH; e++)
      busy_vec[e] = ent_q[e].busy;
    fwd_arr[0] = bus.forwardA;
    fwd_arr[1] = bus.forwardB;
    fwd_arr[2] = bus.forwardC;
    fwd_arr[3] = bus.forwardD;
  end

  assign head1    = head_q + idx_t'(1);
  assign ready    = count_q <= cnt_t'(DEPTH - ROB_LANES);
  assign do_alloc = ready && (bus.alloc_valid != '0);
  assign n_alloc  = do_alloc ? lane_count(bus.alloc_valid) : 3'd0;
  assign ret0     = ent_q[head_q].busy && ent_q[head_q].done;
  assign ret1     = ret0 && ent_q[head1].busy && ent_q[head1].done;
  assign n_ret    = {1'b0, ret0} + {1'b0, ret1};

  rob_forward_capture #(
    .DEPTH (DEPTH),
    .IDXW  (IDXW)
  ) u_fwd (
    .fwd_i  (fwd_arr),
    .busy_i (busy_vec),
    .we_o   (fwd_we),
    .val_o  (fwd_val)
  );

  // entry updates: retire, then capture, then allocate; flush last
  always_comb begin
    ent_d = ent_q;
    if (ret0) ent_d[head_q].busy = 1'b0;
    if (ret1) ent_d[head1].busy = 1'b0;
    for (int e = 0; e < DEPTH; e++) begin
      if (fwd_we[e]) begin
        ent_d[e].done  = 1'b1;
        ent_d[e].value = fwd_val[e];
      end
    end
    if (do_alloc) begin
      for (int k = 0; k < ROB_LANES; k++) begin
        if (bus.alloc_valid[k]) begin
          ent_d[lane_idx[k]].busy  = 1'b1;
          ent_d[lane_idx[k]].done  = 1'b0;
          ent_d[lane_idx[k]].wr    = bus.alloc_wr[k];
          ent_d[lane_idx[k]].dest  = bus.alloc_dest[3*k +: 3];
          ent_d[lane_idx[k]].value = '0;
          ent_d[lane_idx[k]].pc    = bus.alloc_pc[16*k +: 16];
        end
      end
    end
    if (bus.flush) begin
      for (int e = 0; e < DEPTH; e++)
        ent_d[e].busy = 1'b0;
    end
  end

  // pointer and occupancy next state
  always_comb begin
    head_d  = head_q + idx_t'(n_ret);
    tail_d  = tail_q + idx_t'(n_alloc);
    count_d = count_q + cnt_t'(n_alloc) - cnt_t'(n_ret);
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // commit slot contents for the register write ports
  always_comb begin
    wen_d   = '0;
    cv_d    = '0;
    waddr_d = '0;
    wdata_d = '0;
    cpc_d   = '0;
    if (!bus.flush) begin
      if (ret0) begin
        cv_d[0]    = 1'b1;
        wen_d[0]   = ent_q[head_q].wr;
        waddr_d[0] = ent_q[head_q].dest;
        wdata_d[0] = ent_q[head_q].value;
        cpc_d[0]   = ent_q[head_q].pc;
      end
      if (ret1) begin
        cv_d[1]    = 1'b1;
        wen_d[1]   = ent_q[head1].wr;
        waddr_d[1] = ent_q[head1].dest;
        wdata_d[1] = ent_q[head1].value;
        cpc_d[1]   = ent_q[head1].pc;
      end
    end
  end

  // state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      wen_q   <= '0;
      cv_q    <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      cpc_q   <= '0;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      wen_q   <= wen_d;
      cv_q    <= cv_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      cpc_q   <= cpc_d;
    end
  end

  // drive the allocation index lanes
  always_comb begin
    bus.alloc_idx = '0;
    for (int k = 0; k < ROB_LANES; k++)
      bus.alloc_idx[IDXW*k +: IDXW] = lane_idx[k];
  end

  assign bus.alloc_ready  = ready;
  assign bus.wen0         = wen_q[0];
  assign bus.wen1         = wen_q[1];
  assign bus.waddr0       = waddr_q[0];
  assign bus.waddr1       = waddr_q[1];
  assign bus.wdata0       = wdata_q[0];
  assign bus.wdata1       = wdata_q[1];
  assign bus.commit_pc0   = cpc_q[0];
  assign bus.commit_pc1   = cpc_q[1];
  assign bus.commit_valid = cv_q;
  assign bus.rob_count    = count_q;
  assign bus.rob_empty    = (count_q == '0);

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus random
// traffic compared to a program-order queue model.
module tb_reorder_buffer;
  import ooo_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reorder_buffer_if rif();

  reorder_buffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (rif)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int        idx;
    bit        wr;
    bit [2:0]  dest;
    bit [15:0] pc;
    bit        done;
    bit [15:0] val;
  } minst_t;

  minst_t    q[$];
  int        mtail;
  bit [1:0]  e_cv;
  bit        e_wen   [2];
  bit [2:0]  e_waddr [2];
  bit [15:0] e_wdata [2];
  bit [15:0] e_pc    [2];

  function automatic void model_clear();
    q.delete();
    mtail = 0;
    e_cv  = '0;
    for (int s = 0; s < 2; s++) begin
      e_wen[s] = 0;
      e_waddr[s] = '0;
      e_wdata[s] = '0;
      e_pc[s] = '0;
    end
  endfunction

  function automatic void model_edge();
    int cnt0 = q.size();
    int n = 0;
    fwd_bus_t fw [4];
    fw[0] = rif.forwardA;
    fw[1] = rif.forwardB;
    fw[2] = rif.forwardC;
    fw[3] = rif.forwardD;
    if (rif.flush) begin
      model_clear();
      return;
    end
    if (cnt0 > 0 && q[0].done) n = 1;
    if (n == 1 && cnt0 > 1 && q[1].done) n = 2;
    e_cv = '0;
    for (int s = 0; s < 2; s++) begin
      e_wen[s] = 0;
      if (s < n) begin
        e_cv[s]    = 1'b1;
        e_wen[s]   = q[s].wr;
        e_waddr[s] = q[s].dest;
        e_wdata[s] = q[s].val;
        e_pc[s]    = q[s].pc;
      end
    end
    for (int b = 0; b < 4; b++)
      if (fw[b][22])
        foreach (q[i])
          if (q[i].idx == int'(fw[b][21:16])) begin
            q[i].done = 1;
            q[i].val  = fw[b][15:0];
          end
    repeat (n) void'(q.pop_front());
    if (cnt0 <= 60 && rif.alloc_valid != 0)
      for (int k = 0; k < 4; k++)
        if (rif.alloc_valid[k]) begin
          minst_t m;
          m.idx  = mtail;
          m.wr   = rif.alloc_wr[k];
          m.dest = rif.alloc_dest[3*k +: 3];
          m.pc   = rif.alloc_pc[16*k +: 16];
          m.done = 0;
          m.val  = '0;
          q.push_back(m);
          mtail = (mtail + 1) % 64;
        end
  endfunction

  task automatic check_all();
    chk("count", rif.rob_count, q.size());
    chk("empty", rif.rob_empty, q.size() == 0);
    chk("ready", rif.alloc_ready, q.size() <= 60);
    for (int k = 0; k < 4; k++)
      chk($sformatf("idx%0d", k),
          rif.alloc_idx[6*k +: 6], (mtail + k) % 64);
    chk("cvalid", rif.commit_valid, e_cv);
    chk("wen0", rif.wen0, e_wen[0]);
    chk("wen1", rif.wen1, e_wen[1]);
    if (e_cv[0]) begin
      chk("waddr0", rif.waddr0, e_waddr[0]);
      chk("wdata0", rif.wdata0, e_wdata[0]);
      chk("cpc0", rif.commit_pc0, e_pc[0]);
    end
    if (e_cv[1]) begin
      chk("waddr1", rif.waddr1, e_waddr[1]);
      chk("wdata1", rif.wdata1, e_wdata[1]);
      chk("cpc1", rif.commit_pc1, e_pc[1]);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  function automatic fwd_bus_t fb(input int ix, input int v);
    return {1'b1, 6'(ix), 16'(v)};
  endfunction

  task automatic idle_in();
    rif.flush       = 0;
    rif.alloc_valid = '0;
    rif.alloc_wr    = '0;
    rif.alloc_dest  = '0;
    rif.alloc_pc    = '0;
    rif.forwardA    = '0;
    rif.forwardB    = '0;
    rif.forwardC    = '0;
    rif.forwardD    = '0;
  endtask

  task automatic alloc_in(input logic [3:0] m);
    idle_in();
    rif.alloc_valid = m;
    rif.alloc_wr    = 4'($urandom);
    rif.alloc_dest  = 12'($urandom);
    rif.alloc_pc    = {$urandom, $urandom};
  endtask

  task automatic rand_in(input int pa, input int pf, input int pfl);
    logic [3:0] masks [5];
    fwd_bus_t f [4];
    masks = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF};
    alloc_in(($urandom_range(0, 99) < pa) ?
             masks[$urandom_range(1, 4)] : 4'h0);
    for (int b = 0; b < 4; b++) begin
      f[b] = '0;
      if ($urandom_range(0, 99) < pf) begin
        int ix;
        if (q.size() > 0 && $urandom_range(0, 3) != 0)
          ix = q[$urandom_range(0, q.size() - 1)].idx;
        else
          ix = $urandom_range(0, 63);
        f[b] = fb(ix, $urandom);
      end
    end
    rif.forwardA = f[0];
    rif.forwardB = f[1];
    rif.forwardC = f[2];
    rif.forwardD = f[3];
    rif.flush = ($urandom_range(0, 99) < pfl);
  endtask

  task automatic reset_checks(input string tag);
    logic [23:0] idx0;
    idx0 = {6'd3, 6'd2, 6'd1, 6'd0};
    chk({tag, "_count"}, rif.rob_count, 0);
    chk({tag, "_empty"}, rif.rob_empty, 1);
    chk({tag, "_ready"}, rif.alloc_ready, 1);
    chk({tag, "_idx"}, rif.alloc_idx, idx0);
    chk({tag, "_wen0"}, rif.wen0, 0);
    chk({tag, "_wen1"}, rif.wen1, 0);
    chk({tag, "_cv"}, rif.commit_valid, 0);
  endtask

  initial begin
    reset = 0;
    idle_in();
    model_clear();
    #1 reset = 1;
    #1 reset_checks("rst");
    @(negedge clk);
    reset = 0;

    // four instructions, dest r1..r4, pc 0,2,4,6
    idle_in();
    rif.alloc_valid = 4'hF;
    rif.alloc_wr    = 4'hF;
    rif.alloc_dest  = {3'd4, 3'd3, 3'd2, 3'd1};
    rif.alloc_pc    = {16'd6, 16'd4, 16'd2, 16'd0};
    step();
    chk("p1_count", rif.rob_count, 4);
    chk("p1_wen", {rif.wen1, rif.wen0}, 0);
    idle_in();
    rif.forwardB = fb(1, 16'h0055);
    step();
    idle_in();
    rif.forwardA = fb(0, 16'h00AA);
    step();
    chk("p2_wait", rif.commit_valid, 0);
    idle_in();
    step();
    chk("p2_wen0", rif.wen0, 1);
    chk("p2_waddr0", rif.waddr0, 1);
    chk("p2_wdata0", rif.wdata0, 16'h00AA);
    chk("p2_wen1", rif.wen1, 1);
    chk("p2_waddr1", rif.waddr1, 2);
    chk("p2_wdata1", rif.wdata1, 16'h0055);

    // A and D collide on entry 3, D must win
    idle_in();
    rif.forwardA = fb(3, 16'h1111);
    rif.forwardC = fb(2, 16'h3333);
    rif.forwardD = fb(3, 16'h2222);
    step();
    idle_in();
    step();
    chk("p3_wdata0", rif.wdata0, 16'h3333);
    chk("p3_wdata1", rif.wdata1, 16'h2222);
    chk("p3_pc1", rif.commit_pc1, 6);

    // fill to full
    idle_in();
    rif.flush = 1;
    step();
    repeat (16) begin
      alloc_in(4'hF);
      step();
    end
    chk("full_cnt", rif.rob_count, 64);
    chk("full_rdy", rif.alloc_ready, 0);
    alloc_in(4'hF);
    step();
    chk("full_cnt2", rif.rob_count, 64);
    chk("full_tail", rif.alloc_idx[5:0], 0);
    idle_in();
    rif.forwardA = fb(0, 16'h1234);
    rif.forwardB = fb(1, 16'h5678);
    step();
    idle_in();
    step();
    chk("full_cnt3", rif.rob_count, 62);
    chk("full_rdy2", rif.alloc_ready, 0);

    // move tail to 62, drain, then wrap a group
    idle_in();
    rif.flush = 1;
    step();
    repeat (15) begin
      alloc_in(4'hF);
      step();
    end
    alloc_in(4'h3);
    step();
    for (int i = 0; i < 62; i += 4) begin
      idle_in();
      rif.forwardA = fb(i, $urandom);
      rif.forwardB = fb(i + 1, $urandom);
      if (i + 2 < 62) rif.forwardC = fb(i + 2, $urandom);
      if (i + 3 < 62) rif.forwardD = fb(i + 3, $urandom);
      step();
    end
    begin
      int guard = 0;
      while (rif.rob_count != 0 && guard < 200) begin
        idle_in();
        step();
        guard++;
      end
      chk("drain", rif.rob_count, 0);
    end
    idle_in();
    chk("wrap_idx", rif.alloc_idx, {6'd1, 6'd0, 6'd63, 6'd62});
    rif.alloc_valid = 4'hF;
    rif.alloc_wr    = 4'hF;
    rif.alloc_dest  = {3'd7, 3'd6, 3'd5, 3'd4};
    rif.alloc_pc    = {16'h0106, 16'h0104, 16'h0102, 16'h0100};
    step();
    idle_in();
    rif.forwardA = fb(62, 16'hA062);
    rif.forwardB = fb(63, 16'hA063);
    rif.forwardC = fb(0, 16'hA000);
    rif.forwardD = fb(1, 16'hA001);
    step();
    idle_in();
    step();
    chk("wrap_pc0", rif.commit_pc0, 16'h0100);
    chk("wrap_pc1", rif.commit_pc1, 16'h0102);
    idle_in();
    step();
    chk("wrap_pc2", rif.commit_pc0, 16'h0104);
    chk("wrap_pc3", rif.commit_pc1, 16'h0106);
    chk("wrap_head", rif.alloc_idx[5:0], 2);

    // random traffic
    repeat (150) begin rand_in(90, 10, 0); step(); end
    repeat (300) begin rand_in(50, 60, 1); step(); end
    repeat (150) begin rand_in(10, 80, 0); step(); end

    // flush with 10 busy entries, two of them completed
    idle_in();
    rif.flush = 1;
    step();
    alloc_in(4'hF); step();
    alloc_in(4'hF); step();
    alloc_in(4'h3); step();
    idle_in();
    rif.forwardA = fb(0, 16'h0BAD);
    rif.forwardB = fb(1, 16'h0BAD);
    step();
    alloc_in(4'hF);
    rif.forwardC = fb(5, 16'h0C0C);
    rif.flush = 1;
    step();
    chk("fl_count", rif.rob_count, 0);
    chk("fl_empty", rif.rob_empty, 1);
    chk("fl_wen0", rif.wen0, 0);
    chk("fl_wen1", rif.wen1, 0);

    // asynchronous reset in the middle of a cycle
    repeat (20) begin rand_in(80, 30, 0); step(); end
    #2 reset = 1;
    #1 reset_checks("arst");
    model_clear();
    @(negedge clk);
    reset = 0;
    repeat (30) begin rand_in(60, 50, 0); step(); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
